uart_alu_intf: RTL and testbench
================================

# uart_alu_intf

Sequencer between the UART receiver and the ALU/transmitter pair. It collects three received bytes in order (operand A, operand B, opcode) and presents them to a combinational ALU. It then latches the ALU result and hands it to the UART transmitter with a start/done handshake. Upstream is the receiver's byte/valid output; downstream is the ALU operand inputs and the transmitter's data/start inputs.

## Interface
- NB_DATA, 8, width of received bytes, operands and result
- NB_OP, 6, opcode width; taken from bits [NB_OP-1:0] of the third byte
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_DATA  byte from UART receiver
- i_rx_valid  in  1  receiver byte-valid, nominally a one-cycle pulse
- i_alu_result  in  NB_DATA  combinational ALU result for current o_data_a/o_data_b/o_op
- i_tx_done  in  1  transmitter finished sending (one-cycle pulse)
- o_data_a  out  NB_DATA  operand A register to ALU
- o_data_b  out  NB_DATA  operand B register to ALU
- o_op  out  NB_OP  opcode register to ALU
- o_tx_data  out  NB_DATA  latched result to transmitter
- o_tx_start  out  1  transmit request, one cycle
- o_busy  out  1  high while a result is being computed or sent
- o_overrun  out  1  sticky: a byte arrived while busy and was dropped

## Operation
- Byte event = rising edge of i_rx_valid: rx_evt = i_rx_valid & ~valid_q, where valid_q is i_rx_valid registered (reset 0). A valid held N cycles counts as one byte.
- States (one-hot or binary, implementer's choice): WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on rx_evt, o_data_a <= i_rx_data, go WAIT_B.
- WAIT_B: on rx_evt, o_data_b <= i_rx_data, go WAIT_OP.
- WAIT_OP: on rx_evt, o_op <= i_rx_data[NB_OP-1:0], go EXEC.
- EXEC: unconditional; o_tx_data <= i_alu_result, go SEND.
- SEND: o_tx_start = 1; unconditional go WAIT_TX. i_tx_done is ignored in SEND.
- WAIT_TX: stay until i_tx_done = 1, then go WAIT_A.
- o_busy = 1 in EXEC, SEND, WAIT_TX; 0 otherwise.
- rx_evt in EXEC, SEND or WAIT_TX: byte discarded, no register changes, o_overrun <= 1. o_overrun is cleared only by reset.
- rx_evt in the same cycle as i_tx_done in WAIT_TX: counted as overrun; the byte is not taken as operand A.
- Operand/opcode registers hold their values until overwritten by the next transaction. ALU inputs therefore stay stable through SEND/WAIT_TX.
- i_tx_done outside WAIT_TX has no effect.
- Unused state encodings return to WAIT_A on the next clock.

## Timing
- Reset (asynchronous, immediate): state WAIT_A; o_data_a, o_data_b, o_op, o_tx_data = 0; o_tx_start, o_busy, o_overrun = 0; valid_q = 0. Reset mid-transaction discards partial operands.
- Let edge k be the clock edge at which rx_evt for the opcode byte is sampled in WAIT_OP.
  - After edge k: o_op updated; state EXEC; o_busy = 1.
  - Edge k+1: o_tx_data latched from i_alu_result; state SEND; o_tx_start = 1 for exactly the cycle between edges k+1 and k+2.
  - Edge k+2: state WAIT_TX.
  - Edge at which i_tx_done is sampled high: state WAIT_A; o_busy drops after that edge.
- Minimum spacing between result transmission and the next operand A acceptance is 0 cycles after return to WAIT_A.
- o_tx_start and o_busy are decoded from the registered state only; there is no combinational path from inputs.

## Test plan
- Basic: bytes 0x05, 0x03, 0x20 (ALU stub returns A+B) -> o_data_a = 0x05, o_data_b = 0x03, o_op = 0x20. o_tx_data = 0x08 and o_tx_start high exactly one cycle, 2 edges after the opcode byte's rise. o_busy stays high until i_tx_done.
- Stretched valid: i_rx_valid held 3 cycles with 0xAA, then a 1-cycle valid with 0x55 -> o_data_a = 0xAA, o_data_b = 0x55, state WAIT_OP, no extra byte consumed.
- Overrun: byte 0x77 arrives in WAIT_TX -> o_overrun = 1 and stays 1. o_data_a is unchanged. After i_tx_done, the next byte 0x11 loads o_data_a = 0x11.
- Async reset mid-operation: send 0x12 and 0x34, assert i_reset between clock edges -> all outputs 0 immediately. Then 0x01, 0x02, 0x3F yields one normal transaction.
- Opcode truncation: third byte 0xE5 with NB_OP = 6 -> o_op = 0x25.
- Back-to-back: two full transactions, with i_tx_done pulsed 10 cycles after each start -> exactly two o_tx_start pulses, o_tx_data reflecting each result, o_overrun = 0.

Source files
------------

// File: rtl/uart_alu_intf.sv
// uart_alu_intf: collects operand A, operand B and opcode bytes from the UART
// receiver, presents them to a combinational ALU, latches the result and
// hands it to the UART transmitter with a start/done handshake.
module uart_alu_intf #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0] state;
  logic       valid_q;
  logic       rx_evt;

  // A held valid counts as a single byte: only its rising edge is an event.
  always_comb begin
    rx_evt = i_rx_valid & ~valid_q;
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    o_tx_start = (state == SEND);
    o_busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
  end

  // Registered copy of the receiver valid for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) valid_q <= 1'b0;
    else         valid_q <= i_rx_valid;
  end

  // Sequencer FSM with operand, opcode, result and overrun registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= WAIT_A;
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_op      <= '0;
      o_tx_data <= '0;
      o_overrun <= 1'b0;
    end else begin
      case (state)
        WAIT_A: begin
          if (rx_evt) begin
            o_data_a <= i_rx_data;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_evt) begin
            o_data_b <= i_rx_data;
            state    <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_evt) begin
            o_op  <= i_rx_data[NB_OP-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          if (rx_evt) o_overrun <= 1'b1;
          o_tx_data <= i_alu_result;
          state     <= SEND;
        end
        SEND: begin
          if (rx_evt) o_overrun <= 1'b1;
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          // A byte coinciding with tx_done is dropped, not taken as operand A.
          if (rx_evt)    o_overrun <= 1'b1;
          if (i_tx_done) state     <= WAIT_A;
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Testbench for uart_alu_intf: directed byte sequences, an A+B ALU stub and a
// scoreboard that checks every transmit request against queued results.
module tb_uart_alu_intf;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [5:0] op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];

  uart_alu_intf #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .i_alu_result(alu_result),
    .i_tx_done(tx_done),
    .o_data_a(data_a),
    .o_data_b(data_b),
    .o_op(op),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_overrun(overrun)
  );

  // ALU stub: A + B.
  always_comb alu_result = data_a + data_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each transmit request must match the oldest expected result.
  always @(negedge clk) begin
    if (tx_start) begin
      starts++;
      check("start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_start = tx_start;
  end

  task automatic send_byte(input logic [7:0] d, input int unsigned n);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    repeat (n) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                     input logic [7:0] res);
    exp_q.push_back(res);
    send_byte(a, 1);
    send_byte(b, 1);
    send_byte(o, 1);
  endtask

  // Bounded wait for a transmit request; expiry is a failed comparison.
  task automatic wait_start(input string name);
    int unsigned cnt = 0;
    while (!tx_start && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(name, {31'd0, tx_start}, 32'd1);
  endtask

  initial begin
    int s0;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_done = 1'b0;
    #2;
    check("rst_data_a", {24'd0, data_a}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic transaction: 5 + 3 = 8
    txn(8'h05, 8'h03, 8'h20, 8'h08);
    check("basic_a", {24'd0, data_a}, 32'h05);
    check("basic_b", {24'd0, data_b}, 32'h03);
    check("basic_op", {26'd0, op}, 32'h20);
    check("basic_exec_busy", {31'd0, busy}, 32'd1);
    check("basic_exec_nostart", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("basic_send_start", {31'd0, tx_start}, 32'd1);
    @(negedge clk);
    check("basic_waittx_nostart", {31'd0, tx_start}, 32'd0);
    check("basic_waittx_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    check("basic_still_busy", {31'd0, busy}, 32'd1);
    pulse_done();
    check("basic_idle", {31'd0, busy}, 32'd0);

    // Overrun while waiting for the transmitter.
    do_reset();
    txn(8'h05, 8'h03, 8'h20, 8'h08);
    repeat (2) @(negedge clk);
    send_byte(8'h77, 1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_a_kept", {24'd0, data_a}, 32'h05);
    check("ovr_busy", {31'd0, busy}, 32'd1);
    pulse_done();
    send_byte(8'h11, 1);
    check("ovr_next_a", {24'd0, data_a}, 32'h11);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Stretched valid counts once; next byte becomes operand B.
    do_reset();
    send_byte(8'hAA, 3);
    send_byte(8'h55, 1);
    check("str_a", {24'd0, data_a}, 32'hAA);
    check("str_b", {24'd0, data_b}, 32'h55);
    check("str_idle", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'hFF);
    send_byte(8'h01, 1);
    check("str_op_busy", {31'd0, busy}, 32'd1);
    check("str_op", {26'd0, op}, 32'h01);
    wait_start("str_start");
    pulse_done();
    pulse_done();

    // Asynchronous reset between edges mid-transaction.
    do_reset();
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_a", {24'd0, data_a}, 32'd0);
    check("ar_b", {24'd0, data_b}, 32'd0);
    check("ar_op", {26'd0, op}, 32'd0);
    check("ar_tx_data", {24'd0, tx_data}, 32'd0);
    check("ar_start", {31'd0, tx_start}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(8'h01, 8'h02, 8'h3F, 8'h03);
    check("ar_op_after", {26'd0, op}, 32'h3F);
    wait_start("ar_start_after");
    pulse_done();

    // Opcode truncation to 6 bits.
    txn(8'h10, 8'h20, 8'hE5, 8'h30);
    check("trunc_op", {26'd0, op}, 32'h25);
    wait_start("trunc_start");
    pulse_done();

    // Back-to-back transactions with a 10-cycle transmitter.
    do_reset();
    s0 = starts;
    txn(8'h40, 8'h02, 8'h01, 8'h42);
    wait_start("b2b_start1");
    repeat (9) @(negedge clk);
    pulse_done();
    txn(8'hFF, 8'h02, 8'h03, 8'h01);
    wait_start("b2b_start2");
    repeat (9) @(negedge clk);
    pulse_done();
    repeat (3) @(negedge clk);
    check("b2b_starts", starts - s0, 32'd2);
    check("b2b_overrun", {31'd0, overrun}, 32'd0);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    check("total_starts", starts, 32'd7);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
